// File: rtl/payload_engine_sched_if.sv
// Byte-stream, engine-array and result-handshake signals of the payload scheduler.
// The scheduler takes the slave side; the stream source, engine array and result sink take the master side.
interface payload_engine_sched_if #(
  parameter int NUM_ENG = 32,
  parameter int LEN_W   = 11
);
  logic [7:0]         s_data;
  logic               s_valid;
  logic               s_last;
  logic               s_ready;
  logic               eng_sod;
  logic               eng_en;
  logic [7:0]         eng_char;
  logic [NUM_ENG-1:0] eng_match;
  logic [NUM_ENG-1:0] m_match;
  logic [LEN_W-1:0]   m_len;
  logic               m_trunc;
  logic               m_valid;
  logic               m_ready;

  modport master (
    output s_data, s_valid, s_last, eng_match, m_ready,
    input  s_ready, eng_sod, eng_en, eng_char, m_match, m_len, m_trunc, m_valid
  );

  modport slave (
    input  s_data, s_valid, s_last, eng_match, m_ready,
    output s_ready, eng_sod, eng_en, eng_char, m_match, m_len, m_trunc, m_valid
  );
endinterface

// File: rtl/payload_engine_sched.sv
// Sequences one packet at a time through the pattern-engine array: clear, stream, drain, report.
// Optional truncation at MAX_LEN bytes is compiled in with PAYLOAD_SCHED_TRUNC_EN.
module payload_engine_sched #(
  parameter int NUM_ENG   = 32,
  parameter int LEN_W     = 11,
  parameter int MAX_LEN   = 1500,
  parameter int DRAIN_CYC = 3
) (
  input logic                    clk,
  input logic                    rst_n,
  payload_engine_sched_if.slave  bus
);

`ifdef PAYLOAD_SCHED_TRUNC_EN
  localparam bit TRUNC = 1'b1;
`else
  localparam bit TRUNC = 1'b0;
`endif

  localparam int               DC_W    = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);
  localparam logic [LEN_W-1:0] LEN_SAT = '1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    REPORT = 3'd4
  } state_t;

  typedef struct packed {
    logic [NUM_ENG-1:0] match;
    logic [LEN_W-1:0]   len;
    logic               trunc;
  } res_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [DC_W-1:0]  drn_q, drn_d;
  logic             en_q, en_d;
  logic [7:0]       char_q, char_d;
  logic             disc_q, disc_d;
  res_t             res_q, res_d;

  logic accept, present, discard, ready, sod;

  // Past MAX_LEN (truncation builds only) bytes are swallowed but never shown to the engines.
  assign accept  = (state_q == STREAM) && bus.s_valid;
  assign present = accept && (!TRUNC || (int'(cnt_q) < MAX_LEN));
  assign discard = accept && !present;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    en_d    = 1'b0;
    char_d  = char_q;
    disc_d  = disc_q;
    res_d   = res_q;
    ready   = 1'b0;
    sod     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.s_valid) state_d = CLEAR;
      end
      CLEAR: begin
        sod     = 1'b1;
        cnt_d   = '0;
        disc_d  = 1'b0;
        state_d = STREAM;
      end
      STREAM: begin
        ready = 1'b1;
        if (present) begin
          en_d   = 1'b1;
          char_d = bus.s_data;
          if (cnt_q != LEN_SAT) cnt_d = cnt_q + LEN_W'(1);
        end
        if (discard) disc_d = 1'b1;
        if (accept && bus.s_last) begin
          drn_d   = DC_W'(DRAIN_CYC);
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Count covers decoder register, final state flop and end-state flop.
        if (drn_q == '0) begin
          res_d.match = bus.eng_match;
          res_d.len   = cnt_q;
          res_d.trunc = disc_q;
          state_d     = REPORT;
        end else begin
          drn_d = drn_q - DC_W'(1);
        end
      end
      REPORT: begin
        if (bus.m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drn_q   <= '0;
      en_q    <= 1'b0;
      char_q  <= '0;
      disc_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drn_q   <= drn_d;
      en_q    <= en_d;
      char_q  <= char_d;
      disc_q  <= disc_d;
      res_q   <= res_d;
    end
  end

  assign bus.s_ready  = ready;
  assign bus.eng_sod  = sod;
  assign bus.eng_en   = en_q;
  assign bus.eng_char = char_q;
  assign bus.m_match  = res_q.match;
  assign bus.m_len    = res_q.len;
  assign bus.m_trunc  = res_q.trunc;
  assign bus.m_valid  = (state_q == REPORT);

endmodule

// File: tb/tb_payload_engine_sched.sv
// Directed plus randomized packets against a packet-level reference: expected length, truncation,
// presented byte sequence, match vector and result latency are derived from the packet contents.
module tb_payload_engine_sched;
  localparam int NUM_ENG   = 32;
  localparam int LEN_W     = 11;
  localparam int MAX_LEN   = 8;
  localparam int DRAIN_CYC = 3;
`ifdef PAYLOAD_SCHED_TRUNC_EN
  localparam bit TRUNC = 1'b1;
`else
  localparam bit TRUNC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  payload_engine_sched_if #(.NUM_ENG(NUM_ENG), .LEN_W(LEN_W)) bus ();

  payload_engine_sched #(
    .NUM_ENG(NUM_ENG), .LEN_W(LEN_W), .MAX_LEN(MAX_LEN), .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Monitor state: running totals, read (never written) by the stimulus block.
  int   cyc = 0, en_total = 0, sod_total = 0, overlap = 0, t_last = -1, v_rise = -1;
  logic prev_mv = 1'b0;
  logic [7:0] pres_mem [4096];

  // Stand-in engine array: a byte b sets sticky bit (b % NUM_ENG) two cycles after its eng_en.
  logic [NUM_ENG-1:0] eng_r = '0;
  logic       d1_en = 1'b0, d2_en = 1'b0;
  logic [7:0] d1_c = '0, d2_c = '0;
  assign bus.eng_match = eng_r;

  function automatic logic [NUM_ENG-1:0] bit_of(input logic [7:0] b);
    logic [NUM_ENG-1:0] r;
    r = '0;
    r[int'(b) % NUM_ENG] = 1'b1;
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.eng_sod) sod_total <= sod_total + 1;
    if (bus.eng_en) begin
      pres_mem[en_total % 4096] <= bus.eng_char;
      en_total <= en_total + 1;
    end
    if (bus.eng_sod && bus.eng_en) overlap <= overlap + 1;
    if (bus.s_valid && bus.s_ready && bus.s_last) t_last <= cyc;
    if (bus.m_valid && !prev_mv) v_rise <= cyc;
    prev_mv <= bus.m_valid;
    d1_en <= bus.eng_en;
    d1_c  <= bus.eng_char;
    d2_en <= d1_en;
    d2_c  <= d1_c;
    if (bus.eng_sod) eng_r <= '0;
    else if (d2_en)  eng_r <= eng_r | bit_of(d2_c);
  end

  logic [7:0] pkt [64];
  int en_base, sod_base;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_ready"},  64'(bus.s_ready),  0);
    chk({tag, "_eng_sod"},  64'(bus.eng_sod),  0);
    chk({tag, "_eng_en"},   64'(bus.eng_en),   0);
    chk({tag, "_eng_char"}, 64'(bus.eng_char), 0);
    chk({tag, "_m_match"},  64'(bus.m_match),  0);
    chk({tag, "_m_len"},    64'(bus.m_len),    0);
    chk({tag, "_m_trunc"},  64'(bus.m_trunc),  0);
    chk({tag, "_m_valid"},  64'(bus.m_valid),  0);
  endtask

  // gap: 0 continuous valid, 1 valid every other cycle, 2 random bubbles. stop_at>=0 aborts early.
  task automatic send_pkt(input int n, input int gap, input int stop_at);
    int   i, g;
    logic v, acc;
    i = 0;
    g = 0;
    en_base  = en_total;
    sod_base = sod_total;
    while (i < n && i != stop_at && g < 2000) begin
      v = (gap == 0) ? 1'b1 : (gap == 1) ? ((g % 2) == 0) : ($urandom_range(0, 3) != 0);
      bus.s_valid = v;
      bus.s_data  = pkt[i];
      bus.s_last  = (i == n - 1);
      @(negedge clk);
      acc = v && bus.s_ready;
      @(posedge clk);
      #1;
      if (acc) i++;
      g++;
    end
    if (stop_at < 0) begin
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
    end
    chk("bytes_accepted", 64'(i), 64'((stop_at >= 0) ? stop_at : n));
  endtask

  task automatic get_result(input int n, input int hold);
    int                 cap, g;
    logic               exp_trunc;
    logic [NUM_ENG-1:0] em;
    logic               seq_ok;
    cap       = (TRUNC && n > MAX_LEN) ? MAX_LEN : n;
    exp_trunc = TRUNC && (n > MAX_LEN);
    em = '0;
    for (int k = 0; k < cap; k++) em |= bit_of(pkt[k]);
    bus.m_ready = (hold == 0);
    g = 0;
    while (!bus.m_valid && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("m_valid_up", 64'(bus.m_valid), 1);
    chk("m_len",   64'(bus.m_len),   64'(cap));
    chk("m_trunc", 64'(bus.m_trunc), 64'(exp_trunc));
    chk("m_match", 64'(bus.m_match), 64'(em));
    for (int h = 0; h < hold; h++) begin
      bus.s_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("hold_valid",   64'(bus.m_valid), 1);
      chk("hold_match",   64'(bus.m_match), 64'(em));
      chk("hold_len",     64'(bus.m_len),   64'(cap));
      chk("hold_s_ready", 64'(bus.s_ready), 0);
    end
    if (hold > 0) begin
      bus.s_valid = 1'b0;
      chk("hold_no_sod", 64'(sod_total - sod_base), 1);
      bus.m_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("m_valid_down", 64'(bus.m_valid), 0);
    bus.m_ready = 1'b0;
    chk("sod_pulses", 64'(sod_total - sod_base), 1);
    chk("en_pulses",  64'(en_total - en_base), 64'(cap));
    seq_ok = 1'b1;
    for (int k = 0; k < cap; k++)
      if (pres_mem[(en_base + k) % 4096] !== pkt[k]) seq_ok = 1'b0;
    chk("byte_order", 64'(seq_ok), 1);
    chk("latency", 64'(v_rise - t_last), 64'(DRAIN_CYC + 2));
  endtask

  initial begin
    int n;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    #1;
    chk_reset_vals("por");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_s_ready", 64'(bus.s_ready), 0);

    pkt[0] = "A"; pkt[1] = "B"; pkt[2] = "C"; pkt[3] = "D";
    send_pkt(4, 0, -1);  get_result(4, 0);
    send_pkt(4, 1, -1);  get_result(4, 0);
    send_pkt(4, 0, -1);  get_result(4, 10);

    for (int k = 0; k < 12; k++) pkt[k] = 8'($urandom);
    send_pkt(12, 0, -1); get_result(12, 0);

    pkt[0] = 8'h5a;
    send_pkt(1, 0, -1);  get_result(1, 0);

    // Reset during byte 3 of a 10-byte packet.
    for (int k = 0; k < 10; k++) pkt[k] = 8'($urandom);
    send_pkt(10, 0, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) pkt[k] = 8'($urandom);
    send_pkt(5, 0, -1);  get_result(5, 0);

    for (int p = 0; p < 10; p++) begin
      n = $urandom_range(1, 20);
      for (int k = 0; k < n; k++) pkt[k] = 8'($urandom);
      send_pkt(n, 2, -1);
      get_result(n, $urandom_range(0, 3));
    end

    chk("sod_en_overlap", 64'(overlap), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/payload_engine_sched.md
# payload_engine_sched

Scheduler between the packet-payload byte stream and the array of pattern-matching engines. It sequences one packet at a time through the engines:
- clears every engine state flop with a single start-of-data pulse;
- presents payload bytes one per enabled cycle;
- waits for the engine pipeline to settle;
- returns the sticky per-engine match vector with a valid/ready handshake.

## Interface
Parameters:
- NUM_ENG, 32, number of engines; width of the match vectors.
- LEN_W, 11, width of the byte counter and the reported length.
- MAX_LEN, 1500, payload byte cap (used only with truncation compiled in).
- DRAIN_CYC, 3, cycles waited after the last byte before sampling the matches (covers decoder register, final state flop and end-state flop).

Ports:
- clk  in  1  single clock; all flops rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_data  in  8  payload byte.
- s_valid  in  1  byte valid.
- s_last  in  1  marks the final byte of the packet.
- s_ready  out  1  byte accepted when s_valid & s_ready.
- eng_sod  out  1  engine clear pulse; drives the sod inputs of the whole array.
- eng_en  out  1  engine clock enable.
- eng_char  out  8  byte presented to the character decoder.
- eng_match  in  NUM_ENG  engine out bits, one per engine.
- m_match  out  NUM_ENG  captured match vector.
- m_len  out  LEN_W  number of bytes presented to the engines.
- m_trunc  out  1  packet exceeded MAX_LEN.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumer ready.

## Operation
FSM states and transitions:
- IDLE: go to CLEAR when s_valid=1.
- CLEAR: eng_sod=1 for exactly one cycle; byte counter cleared to 0; go to STREAM.
- STREAM: s_ready=1. Each accepted byte is registered: eng_char<=s_data, eng_en<=1 on the next cycle, counter +1. With no accept, eng_en<=0 on the next cycle. An accepted byte with s_last=1 goes to DRAIN.
- DRAIN: s_ready=0, eng_en=0, down-counter loaded with DRAIN_CYC. When it reaches 0, capture eng_match into m_match, capture the counter into m_len, go to REPORT.
- REPORT: m_valid=1; outputs held stable until m_valid & m_ready, then go to IDLE.

Rules:
- eng_en is low in every state except the cycle following an accepted byte. Engine state therefore advances only on real bytes, and valid bubbles are transparent.
- The byte counter saturates at 2^LEN_W-1 and never wraps.
- A packet whose first byte has s_last=1 is a one-byte packet: m_len=1.
- s_ready is never high in IDLE or CLEAR. The first byte is accepted no earlier than 2 cycles after s_valid rises.

## Timing
- Reset values: s_ready=0, eng_sod=0, eng_en=0, eng_char=0, m_match=0, m_len=0, m_trunc=0, m_valid=0; FSM in IDLE.
- Reset asserted mid-packet returns the FSM to IDLE at once. Partially streamed bytes are lost. The next packet starts with a fresh CLEAR.
- Packet-level latency: the last byte is accepted at cycle t; m_valid rises at t+DRAIN_CYC+2.
- Minimum packet period: N bytes + DRAIN_CYC + 4 cycles with m_ready tied high.
- m_match, m_len and m_trunc change only on the DRAIN→REPORT transition.
- eng_sod and eng_en are never high in the same cycle.

## Configuration
- PAYLOAD_SCHED_TRUNC_EN defined:
  - Bytes beyond MAX_LEN are still accepted (s_ready stays 1) and the counter stops at MAX_LEN.
  - eng_en stays 0 for those bytes, so the engines never see them.
  - m_trunc=1 in REPORT when at least one byte was discarded.
- PAYLOAD_SCHED_TRUNC_EN not defined: every byte is presented, the counter saturates at 2^LEN_W-1, and m_trunc is tied to 0.

## Test plan
- Reset, then a 4-byte packet "ABCD" with continuous valid, m_ready=1, eng_match driven to bit 3 two cycles after eng_en of 'D' → eng_sod pulses once, eng_en high 4 cycles, m_valid rises 5 cycles after 'D' is accepted (DRAIN_CYC=3), m_match=0x8, m_len=4.
- Same packet with s_valid deasserted every other cycle → eng_en shows 4 single-cycle pulses with gaps, m_len=4, result identical.
- m_ready held low 10 cycles in REPORT → m_valid, m_match and m_len stable; s_ready=0 throughout; a new s_valid is not accepted until the handshake completes.
- rst_n pulsed low during byte 3 of a 10-byte packet → all outputs at reset values immediately; the next packet produces eng_sod and m_len counted from 0.
- With PAYLOAD_SCHED_TRUNC_EN and MAX_LEN=8, a 12-byte packet → exactly 8 eng_en pulses, m_len=8, m_trunc=1. Without the macro → 12 pulses, m_len=12, m_trunc=0.
- One-byte packet (s_last on the first byte) → CLEAR, one eng_en, m_len=1, m_valid at t+5.
